// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline freeze/flush sequencer with MEM watchdog
// Optional performance counters are enabled with PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             fwd_en,
    input  logic             exe_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             freeze_back,
    output logic             mem_timeout,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_TIMEOUT  = 2'b10
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      state;
    logic [15:0] wait_cnt;
    logic        timeout_q;

    logic exe_match;
    logic mem_match;
    logic hazard;
    logic mwait;
    logic p_timeout;
    logic p_mwait;
    logic p_branch;
    logic p_hazard;

    assign exe_match = (id_src1 == exe_dest) | (id_two_src & (id_src2 == exe_dest));
    assign mem_match = (id_src1 == mem_dest) | (id_two_src & (id_src2 == mem_dest));

    // With forwarding only a load in EXE cannot be bypassed.
    assign hazard = fwd_en ? (exe_mem_r_en & exe_match)
                           : ((exe_wb_en & exe_match) | (mem_wb_en & mem_match));

    assign mwait = mem_req & ~mem_ready;

    assign p_timeout = (state == ST_TIMEOUT);
    assign p_mwait   = ~p_timeout & mwait;
    assign p_branch  = ~p_timeout & ~mwait & exe_branch_taken;
    assign p_hazard  = ~p_timeout & ~mwait & ~exe_branch_taken & hazard;

    // Gated by reset so the stage registers see clean controls during reset.
    assign freeze_pc    = reset & (p_timeout | p_mwait | p_hazard);
    assign freeze_if_id = reset & (p_timeout | p_mwait | p_hazard);
    assign freeze_back  = reset & (p_timeout | p_mwait);
    assign flush_if_id  = reset & p_branch;
    assign flush_id_ex  = reset & (p_branch | p_hazard);

    assign ctrl_state  = state;
    assign mem_timeout = timeout_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_RUN;
            wait_cnt  <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    wait_cnt <= 16'd0;
                    if (mwait) state <= ST_MEM_WAIT;
                end
                ST_MEM_WAIT: begin
                    if (mem_ready) begin
                        state    <= ST_RUN;
                        wait_cnt <= 16'd0;
                    end else if (mwait) begin
                        wait_cnt <= wait_cnt + 16'd1;
                        if (wait_cnt == WAIT_LAST) begin
                            state     <= ST_TIMEOUT;
                            timeout_q <= 1'b1;
                        end
                    end
                end
                ST_TIMEOUT: state <= ST_TIMEOUT;
                default:    state <= ST_RUN;
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic [CNT_W-1:0] memwait_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q   <= '0;
            flush_q   <= '0;
            memwait_q <= '0;
        end else begin
            if (p_hazard && stall_q != '1)   stall_q   <= stall_q + CNT_ONE;
            if (p_branch && flush_q != '1)   flush_q   <= flush_q + CNT_ONE;
            if (p_mwait && memwait_q != '1)  memwait_q <= memwait_q + CNT_ONE;
        end
    end

    assign stall_cnt   = stall_q;
    assign flush_cnt   = flush_q;
    assign memwait_cnt = memwait_q;
`else
    assign stall_cnt   = '0;
    assign flush_cnt   = '0;
    assign memwait_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  id_src1, id_src2, exe_dest, mem_dest;
    logic        id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, fwd_en;
    logic        exe_branch_taken, mem_req, mem_ready;
    logic        freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_back;
    logic        mem_timeout;
    logic [1:0]  ctrl_state;
    logic [31:0] stall_cnt, flush_cnt, memwait_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .fwd_en(fwd_en),
        .exe_branch_taken(exe_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .freeze_back(freeze_back), .mem_timeout(mem_timeout),
        .ctrl_state(ctrl_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .memwait_cnt(memwait_cnt)
    );

    // {freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_back}
    wire [4:0] ctl = {freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_back};
    localparam logic [4:0] C_IDLE   = 5'b00000;
    localparam logic [4:0] C_HAZ    = 5'b11010;
    localparam logic [4:0] C_BRANCH = 5'b00110;
    localparam logic [4:0] C_FROZEN = 5'b11001;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    task automatic idle_inputs();
        id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0;
        exe_dest = 4'd15; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_dest = 4'd15; mem_wb_en = 1'b0; fwd_en = 1'b0;
        exe_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // One clock, ending on the falling edge where inputs change.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("rst_ctl", 32'(ctl), 32'(C_IDLE));
        check("rst_state", 32'(ctrl_state), 32'd0);
        check("rst_timeout", 32'(mem_timeout), 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Load-use with forwarding: one-cycle stall
        fwd_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd4; id_src1 = 4'd4;
        #1 check("loaduse_ctl", 32'(ctl), 32'(C_HAZ));
        cyc();
        idle_inputs();
        #1 check("loaduse_release", 32'(ctl), 32'(C_IDLE));
        check("loaduse_stall_cnt", stall_cnt, cnt_exp(1));

        // Forwarding covers a non-load match
        fwd_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd4; id_src1 = 4'd4;
        #1 check("fwd_alu_nostall", 32'(ctl), 32'(C_IDLE));
        cyc();
        idle_inputs();

        // No forwarding: MEM-stage match on src2
        mem_wb_en = 1'b1; mem_dest = 4'd7; id_two_src = 1'b1; id_src2 = 4'd7;
        #1 check("nofwd_src2_ctl", 32'(ctl), 32'(C_HAZ));
        cyc();
        id_two_src = 1'b0;
        #1 check("nofwd_one_src_ctl", 32'(ctl), 32'(C_IDLE));
        cyc();
        idle_inputs();
        #1 check("nofwd_stall_cnt", stall_cnt, cnt_exp(2));

        // Branch wins over a load-use hazard
        fwd_en = 1'b1; exe_mem_r_en = 1'b1; exe_dest = 4'd4; id_src1 = 4'd4;
        exe_branch_taken = 1'b1;
        #1 check("branch_haz_ctl", 32'(ctl), 32'(C_BRANCH));
        cyc();
        idle_inputs();
        #1 check("branch_flush_cnt", flush_cnt, cnt_exp(1));
        check("branch_stall_cnt", stall_cnt, cnt_exp(2));

        // Memory wait of 5 cycles with a branch held in EXE
        mem_req = 1'b1; mem_ready = 1'b0; exe_branch_taken = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("mwait_ctl_%0d", i), 32'(ctl), 32'(C_FROZEN));
            check($sformatf("mwait_state_%0d", i), 32'(ctrl_state), (i == 0) ? 32'd0 : 32'd1);
            cyc();
        end
        mem_ready = 1'b1;
        #1 check("mwait_release_ctl", 32'(ctl), 32'(C_BRANCH));
        check("mwait_release_state", 32'(ctrl_state), 32'd1);
        cyc();
        idle_inputs();
        #1 check("mwait_back_run", 32'(ctrl_state), 32'd0);
        check("mwait_memwait_cnt", memwait_cnt, cnt_exp(5));
        check("mwait_flush_cnt", flush_cnt, cnt_exp(2));

        // Watchdog: 9 frozen cycles then TIMEOUT
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            #1;
            check($sformatf("to_ctl_%0d", i), 32'(ctl), 32'(C_FROZEN));
            check($sformatf("to_state_%0d", i), 32'(ctrl_state), (i == 0) ? 32'd0 : 32'd1);
            check($sformatf("to_flag_%0d", i), 32'(mem_timeout), 32'd0);
            cyc();
        end
        #1 check("to_state", 32'(ctrl_state), 32'd2);
        check("to_flag", 32'(mem_timeout), 32'd1);
        check("to_ctl", 32'(ctl), 32'(C_FROZEN));
        mem_ready = 1'b1; exe_branch_taken = 1'b1;
        cyc();
        #1 check("to_sticky_state", 32'(ctrl_state), 32'd2);
        check("to_sticky_ctl", 32'(ctl), 32'(C_FROZEN));
        check("to_memwait_cnt", memwait_cnt, cnt_exp(14));
        #1 reset = 1'b0;
        #1 check("to_rst_state", 32'(ctrl_state), 32'd0);
        check("to_rst_flag", 32'(mem_timeout), 32'd0);
        check("to_rst_ctl_forced", 32'(ctl), 32'(C_IDLE));
        check("to_rst_cnt", memwait_cnt, 32'd0);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        #1 check("to_after_rst_ctl", 32'(ctl), 32'(C_IDLE));

        // Asynchronous reset between edges while in MEM_WAIT
        mem_req = 1'b1; mem_ready = 1'b0;
        cyc();
        cyc();
        #1 check("async_pre_state", 32'(ctrl_state), 32'd1);
        #2 reset = 1'b0;
        #1 check("async_state", 32'(ctrl_state), 32'd0);
        check("async_ctl", 32'(ctl), 32'(C_IDLE));
        check("async_cnt", memwait_cnt, 32'd0);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        #1 check("async_after_ctl", 32'(ctl), 32'(C_IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
